mips_instr_feeder: RTL and testbench



---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_feeder_ram.sv | 33 +++
 rtl/mips_instr_feeder.sv | 200 ++++++++++++++++++++
 tb/tb_mips_instr_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared widths, constants and enums for the MIPS core and its
//               instruction feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Core datapath widths, used as parameter defaults by attached blocks
    localparam int INSTR_WIDTH = 32;
    localparam int PC_WIDTH    = 32;

    // All-zero word is "sll $0,$0,0", the architectural no-op
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    // Feeder presentation mode
    typedef enum logic {
        FEED_STREAM = 1'b0,
        FEED_ROM    = 1'b1
    } feeder_mode_e;

endpackage
`default_nettype wire

// File: rtl/mips_feeder_ram.sv
`default_nettype none
// ============================================================================
// Module      : mips_feeder_ram
// Description : DEPTH x INSTR_W instruction store for mips_instr_feeder.
//               Synchronous write, asynchronous read, no reset on the array.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_feeder_ram #(
    parameter int DEPTH   = 64,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [INSTR_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [INSTR_W-1:0]       rdata
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    // Write port: word captured on the clock edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port is combinational so the feeder can register the word itself
    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/mips_instr_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mips_instr_feeder
// Description : Instruction source for the MIPS fetch stage. A host loads
//               words through a valid/ready port; the core sees them either
//               in FIFO order (STREAM) or indexed by PC (ROM). Reports
//               out-of-range ROM fetches and STREAM underruns.
//               Optional feature macro: MIPS_FEEDER_UNDERRUN_CNT_EN
//               (defined: saturating underrun counter; undefined: tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_instr_feeder
    import mips_pkg::*;
#(
    parameter int              DEPTH     = 64,
    parameter int              INSTR_W   = INSTR_WIDTH,
    parameter int              PC_W      = PC_WIDTH,
    parameter logic [PC_W-1:0] BASE_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic                     flush,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [INSTR_W-1:0]       ld_data,
    input  logic                     fetch_en,
    input  logic [PC_W-1:0]          pc,
    output logic [INSTR_W-1:0]       instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     oor_err,
    output logic [15:0]              underrun_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [INSTR_W-1:0] NOP_W  = INSTR_W'(NOP_INSTR);
    localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);

    // Registered state
    feeder_mode_e        mode_q;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q,  count_d;
    logic [INSTR_W-1:0]  instr_q,  instr_d;
    logic                oor_q,    oor_d;
    logic                empty_q,  empty_d;
    logic                full_q,   full_d;

    // Combinational helpers
    feeder_mode_e        mode_in;
    logic                mode_chg;
    logic                clear;
    logic                push;
    logic                pop;
    logic [PC_W-1:0]     rom_off;
    logic [PC_W-1:0]     rom_idx;
    logic                rom_hit;
    logic [AW-1:0]       rd_addr;
    logic [INSTR_W-1:0]  rd_data;

    // A mode switch behaves exactly like a flush, detected against the
    // mode seen on the previous edge.
    assign mode_in  = feeder_mode_e'(mode);
    assign mode_chg = (mode_in != mode_q);
    assign clear    = flush | mode_chg;

    // Handshake is refused while in reset and during a clearing cycle; no
    // bypass from a same-cycle pop, so a full FIFO stays not-ready.
    assign ld_ready = rst_n & ~clear & (count_q < DEPTH_C);
    assign push     = ld_valid & ld_ready;
    assign pop      = (mode_q == FEED_STREAM) & fetch_en & ~empty_q & ~clear;

    // ROM lookup: pc below BASE_ADDR wraps to a huge index and misses
    assign rom_off  = pc - BASE_ADDR;
    assign rom_idx  = rom_off >> 2;
    assign rom_hit  = (rom_off[1:0] == 2'b00) && (rom_idx < PC_W'(count_q));

    assign rd_addr  = (mode_q == FEED_ROM) ? rom_idx[AW-1:0] : rd_ptr_q;

    mips_feeder_ram #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (ld_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Next-state: pointers, occupancy, presented instruction and error pulse
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        oor_d    = 1'b0;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            instr_d  = NOP_W;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (mode_q == FEED_STREAM) begin
                if (fetch_en) begin
                    if (pop) begin
                        instr_d  = rd_data;
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end else begin
                        instr_d  = NOP_W;
                    end
                end
                if (push && !pop) begin
                    count_d = count_q + CW'(1);
                end else if (pop && !push) begin
                    count_d = count_q - CW'(1);
                end
            end else begin
                if (fetch_en) begin
                    if (rom_hit) begin
                        instr_d = rd_data;
                    end else begin
                        instr_d = NOP_W;
                        oor_d   = 1'b1;
                    end
                end
                if (push) begin
                    count_d = count_q + CW'(1);
                end
            end
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= FEED_STREAM;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            instr_q  <= NOP_W;
            oor_q    <= 1'b0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            mode_q   <= mode_in;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            oor_q    <= oor_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

`ifdef MIPS_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] underrun_q, underrun_d;

    // Saturating count of STREAM fetches that found nothing to deliver
    always_comb begin
        underrun_d = underrun_q;
        if (!clear && (mode_q == FEED_STREAM) && fetch_en && empty_q &&
            (underrun_q != 16'hFFFF)) begin
            underrun_d = underrun_q + 16'd1;
        end
    end

    // Underrun counter register; flush and mode change leave it intact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_q <= 16'h0000;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = 16'h0000;
`endif

    assign instr   = instr_q;
    assign count   = count_q;
    assign empty   = empty_q;
    assign full    = full_q;
    assign oor_err = oor_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mips_instr_feeder
// Description : Self-checking bench for mips_instr_feeder. Two instances
//               (DEPTH 4 and 16) share one stimulus stream and are compared
//               against a queue-style reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_instr_feeder;

    localparam logic [31:0] BASE = 32'h0040_0000;
`ifdef MIPS_FEEDER_UNDERRUN_CNT_EN
    localparam bit UND_ON = 1'b1;
`else
    localparam bit UND_ON = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        mode     = 1'b0;
    logic        flush    = 1'b0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_data  = '0;
    logic        fetch_en = 1'b0;
    logic [31:0] pc       = '0;

    logic        ld_ready_a, ld_ready_b;
    logic [31:0] instr_a, instr_b;
    logic [2:0]  count_a;
    logic [4:0]  count_b;
    logic        empty_a, empty_b, full_a, full_b, oor_a, oor_b;
    logic [15:0] und_a, und_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_instr_feeder #(.DEPTH(4), .INSTR_W(32), .PC_W(32), .BASE_ADDR(BASE)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready_a), .ld_data(ld_data),
        .fetch_en(fetch_en), .pc(pc), .instr(instr_a), .count(count_a),
        .empty(empty_a), .full(full_a), .oor_err(oor_a), .underrun_cnt(und_a)
    );

    mips_instr_feeder #(.DEPTH(16), .INSTR_W(32), .PC_W(32), .BASE_ADDR(BASE)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode), .flush(flush),
        .ld_valid(ld_valid), .ld_ready(ld_ready_b), .ld_data(ld_data),
        .fetch_en(fetch_en), .pc(pc), .instr(instr_b), .count(count_b),
        .empty(empty_b), .full(full_b), .oor_err(oor_b), .underrun_cnt(und_b)
    );

    // ---------------- reference model ----------------
    // Each instance holds a list of loaded words (head/size over a large
    // ring); STREAM consumes from the head, ROM indexes from the head.
    logic [31:0] m_mem [2][1024];
    int          m_head [2];
    int          m_size [2];
    logic [31:0] m_instr [2];
    bit          m_oor [2];
    int          m_und [2];
    bit          m_mode;

    function automatic int dep(input int k);
        return (k == 0) ? 4 : 16;
    endfunction

    function automatic bit e_ready(input int k);
        bit clr;
        clr = flush || (mode != m_mode);
        return rst_n && !clr && (m_size[k] < dep(k));
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_head[k] = 0; m_size[k] = 0; m_instr[k] = '0; m_oor[k] = 1'b0; m_und[k] = 0;
        end
        m_mode = 1'b0;
    endtask

    task automatic m_step();
        bit          clr;
        bit          psh;
        logic [31:0] off;
        clr = flush || (mode != m_mode);
        for (int k = 0; k < 2; k++) begin
            psh = ld_valid && e_ready(k);
            if (clr) begin
                m_head[k] = 0; m_size[k] = 0; m_instr[k] = '0; m_oor[k] = 1'b0;
            end else begin
                m_oor[k] = 1'b0;
                if (!m_mode) begin
                    if (fetch_en) begin
                        if (m_size[k] > 0) begin
                            m_instr[k] = m_mem[k][m_head[k]];
                            m_head[k]  = (m_head[k] + 1) % 1024;
                            m_size[k]  = m_size[k] - 1;
                        end else begin
                            m_instr[k] = '0;
                            if (m_und[k] < 65535) m_und[k] = m_und[k] + 1;
                        end
                    end
                end else if (fetch_en) begin
                    off = pc - BASE;
                    if (off[1:0] == 2'b00 && (off >> 2) < 32'(m_size[k])) begin
                        m_instr[k] = m_mem[k][(m_head[k] + int'(off >> 2)) % 1024];
                    end else begin
                        m_instr[k] = '0;
                        m_oor[k]   = 1'b1;
                    end
                end
                if (psh) begin
                    m_mem[k][(m_head[k] + m_size[k]) % 1024] = ld_data;
                    m_size[k] = m_size[k] + 1;
                end
            end
        end
        m_mode = mode;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic check_out(input int k);
        chk("instr", k, (k == 0) ? instr_a : instr_b, m_instr[k]);
        chk("count", k, (k == 0) ? 32'(count_a) : 32'(count_b), 32'(m_size[k]));
        chk("empty", k, 32'((k == 0) ? empty_a : empty_b), 32'(m_size[k] == 0));
        chk("full",  k, 32'((k == 0) ? full_a : full_b), 32'(m_size[k] == dep(k)));
        chk("oor_err", k, 32'((k == 0) ? oor_a : oor_b), 32'(m_oor[k]));
        chk("underrun_cnt", k, 32'((k == 0) ? und_a : und_b), UND_ON ? 32'(m_und[k]) : 32'd0);
    endtask

    // One clock: handshake check before the edge, outputs after it
    task automatic cyc();
        #1;
        for (int k = 0; k < 2; k++)
            chk("ld_ready", k, 32'((k == 0) ? ld_ready_a : ld_ready_b), 32'(e_ready(k)));
        m_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) check_out(k);
    endtask

    task automatic drive(input bit md, input bit fl, input bit lv, input logic [31:0] d,
                         input bit fe, input logic [31:0] p);
        mode = md; flush = fl; ld_valid = lv; ld_data = d; fetch_en = fe; pc = p;
        cyc();
    endtask

    // Reset asserted between edges; reset values must appear at once
    task automatic do_reset();
        mode = 1'b0; flush = 1'b0; ld_valid = 1'b0; fetch_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_ld_ready", 0, 32'(ld_ready_a), 32'd0);
        chk("rst_ld_ready", 1, 32'(ld_ready_b), 32'd0);
        for (int k = 0; k < 2; k++) check_out(k);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          ld_valid;
        logic [31:0] ld_data;
        bit          fetch_en;
        logic [31:0] exp_instr;
        int          exp_count;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h2001_000A, 1'b0, 32'h0000_0000, 1};
        tbl[1] = '{1'b1, 32'h2002_0014, 1'b0, 32'h0000_0000, 2};
        tbl[2] = '{1'b1, 32'h0022_1820, 1'b0, 32'h0000_0000, 3};
        tbl[3] = '{1'b0, 32'h0000_0000, 1'b1, 32'h2001_000A, 2};
        tbl[4] = '{1'b0, 32'h0000_0000, 1'b1, 32'h2002_0014, 1};
        tbl[5] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0022_1820, 0};
        tbl[6] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 0};
        tbl[7] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0};

        do_reset();

        // STREAM basic
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, tbl[i].ld_valid, tbl[i].ld_data, tbl[i].fetch_en, 32'h0);
            chk("tbl_instr", 0, instr_a, tbl[i].exp_instr);
            chk("tbl_count", 0, 32'(count_a), 32'(tbl[i].exp_count));
        end
        chk("basic_underrun", 0, 32'(und_a), UND_ON ? 32'd1 : 32'd0);
        chk("basic_empty", 0, 32'(empty_a), 32'd1);

        // Full and wrap on the 4-deep instance
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 32'h0);
        chk("full_after4", 0, 32'(full_a), 32'd1);
        mode = 1'b0; flush = 1'b0; ld_valid = 1'b1; ld_data = 32'hA000_0004; fetch_en = 1'b0;
        #1;
        chk("ready_when_full", 0, 32'(ld_ready_a), 32'd0);
        cyc();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        chk("wrap_pop0", 0, instr_a, 32'hA000_0000);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        for (int i = 5; i < 7; i++) drive(1'b0, 1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        chk("wrap_last", 0, instr_a, 32'hA000_0006);
        chk("wrap_count", 0, 32'(count_a), 32'd0);

        // Simultaneous push/pop at count 2
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'hB000_0000, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'hB000_0001, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'hB000_0002, 1'b1, 32'h0);
        chk("pushpop_count", 0, 32'(count_a), 32'd2);
        chk("pushpop_instr", 0, instr_a, 32'hB000_0000);

        // ROM lookup
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b1, 32'hC000_0000 + 32'(i), 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0008);
        chk("rom_word2", 1, instr_b, 32'hC000_0002);
        chk("rom_word2_oor", 1, 32'(oor_b), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0020);
        chk("rom_past_end", 1, instr_b, 32'h0);
        chk("rom_past_end_oor", 1, 32'(oor_b), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0006);
        chk("rom_misalign_oor", 1, 32'(oor_b), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rom_oor_pulse", 1, 32'(oor_b), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_001C);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h003F_FFFC);

        // Mode change clears contents, keeps the underrun count
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 32'hD000_0000 + 32'(i), 1'b0, 32'h0);
        chk("pre_toggle_count", 1, 32'(count_b), 32'd5);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("toggle_count", 1, 32'(count_b), 32'd0);
        chk("toggle_instr", 1, instr_b, 32'h0);

        // Reset between edges with count 3, then underruns after reset
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 32'hE000_0000 + 32'(i), 1'b0, 32'h0);
        chk("pre_reset_count", 1, 32'(count_b), 32'd3);
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
        chk("underrun5", 1, 32'(und_b), UND_ON ? 32'd5 : 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            mode     = ($urandom_range(0, 29) == 0) ? ~mode : mode;
            flush    = ($urandom_range(0, 39) == 0);
            ld_valid = 1'($urandom_range(0, 1));
            ld_data  = $urandom;
            fetch_en = 1'($urandom_range(0, 1));
            pc       = ($urandom_range(0, 7) == 0) ? $urandom : BASE + 32'($urandom_range(0, 72));
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
